inc_overflow_counter: RTL and testbench

- Sequential up-counter with a correct carry/overflow indication; the incrementing counterpart of the team's decrementer blocks.
- Adds a fixed STEP to a loadable count each enabled cycle.
- Detects carry-out from the WIDTH-bit sum, reports it as a one-cycle pulse plus a sticky flag, and halts until software acknowledges.
- Sits in counter/timer datapaths as the reference-correct overflow source for checker benches.

---
 rtl/inc_overflow_counter_if.sv | 29 ++
 rtl/inc_overflow_counter.sv | 134 +++++++++++++
 tb/tb_inc_overflow_counter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/inc_overflow_counter_if.sv
// inc_overflow_counter_if
//   Control and status bundle for inc_overflow_counter.
//   master : drives load/load_val/start/stop/ack_ovf and observes status
//   slave  : the counter; observes controls, drives count/overflow/ovf_sticky/busy
// Parameters:
//   WIDTH  count width in bits; must match the counter's WIDTH
interface inc_overflow_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             ack_ovf;
    logic [WIDTH-1:0] count;
    logic             overflow;
    logic             ovf_sticky;
    logic             busy;

    modport master (
        output load, load_val, start, stop, ack_ovf,
        input  count, overflow, ovf_sticky, busy
    );

    modport slave (
        input  load, load_val, start, stop, ack_ovf,
        output count, overflow, ovf_sticky, busy
    );
endinterface

// File: rtl/inc_overflow_counter.sv
// inc_overflow_counter
//   Loadable up-counter that adds STEP each RUN cycle, takes the carry from
//   the full WIDTH+1 bit sum, flags it as a one-cycle overflow pulse plus a
//   sticky bit, and halts until the overflow is acknowledged.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   inc_overflow_counter_if.slave
//           load/load_val  load count, force IDLE, clear flags
//           start/stop     IDLE->RUN / RUN->IDLE requests
//           ack_ovf        clear ovf_sticky; HALT->IDLE
//           count          registered count
//           overflow       one-cycle pulse after the wrapping increment
//           ovf_sticky     held until ack_ovf, load or rst
//           busy           high while in RUN
// Build option:
//   INC_SATURATE_EN  when defined, a carrying increment leaves count at all
//                    ones instead of the wrapped value
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | count holds, waiting for start
// RUN   | count advances by STEP every cycle
// HALT  | overflow seen, count holds, waiting for ack_ovf (or load)
module inc_overflow_counter #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inc_overflow_counter_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 16 || STEP < 1 || STEP > ((1 << WIDTH) - 1)) begin : g_param_err
        $error("inc_overflow_counter: WIDTH or STEP out of legal range");
    end

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] count_q,      count_d;
    logic             overflow_q,   overflow_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             busy_q,       busy_d;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] next_count;

    // Carry is taken from the widened sum so no bit is lost before the compare.
    always_comb begin
        sum   = {1'b0, count_q} + STEP_EXT;
        carry = sum[WIDTH];
`ifdef INC_SATURATE_EN
        next_count = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        next_count = sum[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        overflow_d   = 1'b0;
        ovf_sticky_d = ovf_sticky_q;

        if (bus.load) begin
            count_d      = bus.load_val;
            state_d      = ST_IDLE;
            ovf_sticky_d = 1'b0;
        end else begin
            if (bus.ack_ovf) begin
                ovf_sticky_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!bus.stop && bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d = next_count;
                        if (carry) begin
                            // A fresh overflow re-arms the sticky bit even
                            // if a stale ack arrives in the same cycle.
                            overflow_d   = 1'b1;
                            ovf_sticky_d = 1'b1;
                            state_d      = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.ack_ovf) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            ovf_sticky_q <= ovf_sticky_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_inc_overflow_counter.sv
module tb_inc_overflow_counter;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       ovf;
        logic       stk;
        logic       bsy;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst2;
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inc_overflow_counter_if #(.WIDTH(4)) if1 ();
    inc_overflow_counter_if #(.WIDTH(4)) if2 ();

    inc_overflow_counter #(.WIDTH(4), .STEP(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    inc_overflow_counter #(.WIDTH(4), .STEP(5)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

    // Value a carrying increment leaves in count.
    function automatic logic [3:0] wr(input logic [3:0] v);
`ifdef INC_SATURATE_EN
        return 4'hf;
`else
        return v;
`endif
    endfunction

    task automatic compare(input int dut, input exp_t e, input logic [3:0] c,
                           input logic o, input logic s, input logic b);
        checks++;
        if ({c, o, s, b} !== {e.cnt, e.ovf, e.stk, e.bsy}) begin
            errors++;
            $display("FAIL dut%0d %s: got count=%0d ovf=%b sticky=%b busy=%b, expected count=%0d ovf=%b sticky=%b busy=%b",
                     dut, e.name, c, o, s, b, e.cnt, e.ovf, e.stk, e.bsy);
        end
    endtask

    // Monitors: one expectation is consumed per clock edge, sampled clear of the edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare(1, e, if1.count, if1.overflow, if1.ovf_sticky, if1.busy);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q2.size() > 0) begin
            e = q2.pop_front();
            compare(2, e, if2.count, if2.overflow, if2.ovf_sticky, if2.busy);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input int sel, input string nm, input bit r, input bit ld,
                        input logic [3:0] lv, input bit st, input bit sp, input bit ak,
                        input logic [3:0] ec, input bit eo, input bit es, input bit eb);
        exp_t e;
        @(negedge clk);
        e = '{nm, ec, eo, es, eb};
        if (sel == 1) begin
            rst1 = r; if1.load = ld; if1.load_val = lv;
            if1.start = st; if1.stop = sp; if1.ack_ovf = ak;
            q1.push_back(e);
        end else begin
            rst2 = r; if2.load = ld; if2.load_val = lv;
            if2.start = st; if2.stop = sp; if2.ack_ovf = ak;
            q2.push_back(e);
        end
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        if1.load = 0; if1.load_val = 0; if1.start = 0; if1.stop = 0; if1.ack_ovf = 0;
        if2.load = 0; if2.load_val = 0; if2.start = 0; if2.stop = 0; if2.ack_ovf = 0;

        // STEP=1: wrap from 13 through 15 to 0
        step(1, "reset",       1, 0, 0,  0, 0, 0,  0,       0, 0, 0);
        step(1, "load13",      0, 1, 13, 0, 0, 0,  13,      0, 0, 0);
        step(1, "start",       0, 0, 0,  1, 0, 0,  13,      0, 0, 1);
        step(1, "run14",       0, 0, 0,  0, 0, 0,  14,      0, 0, 1);
        step(1, "run15",       0, 0, 0,  0, 0, 0,  15,      0, 0, 1);
        step(1, "wrap",        0, 0, 0,  0, 0, 0,  wr(0),   1, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, "halt_hold", 0, 0, 0, 0, 0, 0, wr(0),   0, 1, 0);
        step(1, "halt_start",  0, 0, 0,  1, 0, 0,  wr(0),   0, 1, 0);
        step(1, "ack",         0, 0, 0,  0, 0, 1,  wr(0),   0, 0, 0);
        step(1, "load0",       0, 1, 0,  0, 0, 0,  0,       0, 0, 0);
        step(1, "restart",     0, 0, 0,  1, 0, 0,  0,       0, 0, 1);
        for (int i = 1; i <= 15; i++)
            step(1, "run_up",  0, 0, 0,  0, 0, 0,  4'(i),   0, 0, 1);
        // count is 15 in RUN: load must beat the wrap
        step(1, "load_prio",   0, 1, 3,  0, 0, 0,  3,       0, 0, 0);

        // stop handling
        step(1, "load0b",      0, 1, 0,  0, 0, 0,  0,       0, 0, 0);
        step(1, "start_b",     0, 0, 0,  1, 0, 0,  0,       0, 0, 1);
        step(1, "run1",        0, 0, 0,  0, 0, 0,  1,       0, 0, 1);
        step(1, "run2",        0, 0, 0,  0, 0, 0,  2,       0, 0, 1);
        step(1, "stop",        0, 0, 0,  0, 1, 0,  2,       0, 0, 0);
        step(1, "start_stop",  0, 0, 0,  1, 1, 0,  2,       0, 0, 0);
        step(1, "idle_hold",   0, 0, 0,  0, 0, 0,  2,       0, 0, 0);

        // reset in the middle of a run
        step(1, "load5",       0, 1, 5,  0, 0, 0,  5,       0, 0, 0);
        step(1, "start_c",     0, 0, 0,  1, 0, 0,  5,       0, 0, 1);
        step(1, "run6",        0, 0, 0,  0, 0, 0,  6,       0, 0, 1);
        step(1, "run7",        0, 0, 0,  0, 0, 0,  7,       0, 0, 1);
        step(1, "rst_mid",     1, 0, 0,  0, 0, 0,  0,       0, 0, 0);
        step(1, "rst_release", 0, 0, 0,  0, 0, 0,  0,       0, 0, 0);

        // long run from 0: single overflow at 15->0, then halted
        step(1, "start40",     0, 0, 0,  1, 0, 0,  0,       0, 0, 1);
        for (int i = 1; i <= 40; i++)
            step(1, "run40",   0, 0, 0,  0, 0, 0,
                 (i <= 15) ? 4'(i) : wr(0), (i == 16), (i >= 16), (i <= 15));

        // STEP=5: 10 is the last count that does not carry, 11 carries to 0
        step(2, "reset",       1, 0, 0,  0, 0, 0,  0,       0, 0, 0);
        step(2, "load10",      0, 1, 10, 0, 0, 0,  10,      0, 0, 0);
        step(2, "start",       0, 0, 0,  1, 0, 0,  10,      0, 0, 1);
        step(2, "run15",       0, 0, 0,  0, 0, 0,  15,      0, 0, 1);
        step(2, "wrap4",       0, 0, 0,  0, 0, 0,  wr(4),   1, 1, 0);
        step(2, "halt_hold",   0, 0, 0,  0, 0, 0,  wr(4),   0, 1, 0);
        step(2, "ack",         0, 0, 0,  0, 0, 1,  wr(4),   0, 0, 0);
        step(2, "load11",      0, 1, 11, 0, 0, 0,  11,      0, 0, 0);
        step(2, "start_b",     0, 0, 0,  1, 0, 0,  11,      0, 0, 1);
        step(2, "wrap0",       0, 0, 0,  0, 0, 0,  wr(0),   1, 1, 0);
        step(2, "load_halt",   0, 1, 2,  0, 0, 0,  2,       0, 0, 0);
        step(2, "idle_hold",   0, 0, 0,  0, 0, 0,  2,       0, 0, 0);

        @(negedge clk);
        if1.load = 0; if1.start = 0; if1.stop = 0; if1.ack_ovf = 0;
        if2.load = 0; if2.start = 0; if2.stop = 0; if2.ack_ovf = 0;
        for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++)
            @(posedge clk);
        #3;
        checks++;
        if (q1.size() > 0 || q2.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", q1.size(), q2.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
